// File: rtl/memory_cycle_if.sv
// Memory-stage bus: E/M pipeline inputs into the memory stage and the
// registered M/W outputs plus the writeback result heading back upstream.
// The slave modport is the memory stage; the master modport is its environment.
interface memory_cycle_if;

    // M-stage inputs, driven by the execute stage's E/M register
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;

    // W-stage outputs, registered at the M/W boundary
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;

    // Combinational writeback value and misalignment status
    logic [31:0] ResultW;
    logic        MisalignW;
    logic [7:0]  MisalignCnt;

    modport master (
        output RegWriteM,
        output MemWriteM,
        output ResultSrcM,
        output ALUResultM,
        output WriteDataM,
        output RdM,
        output PCPlus4M,
        input  RegWriteW,
        input  RdW,
        input  ResultSrcW,
        input  ALUResultW,
        input  ReadDataW,
        input  PCPlus4W,
        input  ResultW,
        input  MisalignW,
        input  MisalignCnt
    );

    modport slave (
        input  RegWriteM,
        input  MemWriteM,
        input  ResultSrcM,
        input  ALUResultM,
        input  WriteDataM,
        input  RdM,
        input  PCPlus4M,
        output RegWriteW,
        output RdW,
        output ResultSrcW,
        output ALUResultW,
        output ReadDataW,
        output PCPlus4W,
        output ResultW,
        output MisalignW,
        output MisalignCnt
    );

endinterface

// File: rtl/memory_cycle.sv
// Memory stage (M) of the five-stage RV32 core: word-addressed data memory,
// full-word loads/stores, the M/W pipeline register and the writeback mux.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// stores are suppressed and misaligned accesses are flagged and counted.
module memory_cycle #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    memory_cycle_if.slave bus
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned SRC_W = 2;
    localparam int unsigned CNT_W = 8;

    localparam logic [SRC_W-1:0] SRC_ALU  = 2'b00;
    localparam logic [SRC_W-1:0] SRC_LOAD = 2'b01;
    localparam logic [SRC_W-1:0] SRC_PC4  = 2'b10;

    // Data memory; contents survive reset and start out zeroed
    logic [XLEN-1:0]   r_mem [DEPTH] = '{default: '0};

    logic [ADDR_W-1:0] w_idx;
    logic [XLEN-1:0]   w_rdata;
    logic              w_store_en;

    logic              r_reg_write_w;
    logic [REG_W-1:0]  r_rd_w;
    logic [SRC_W-1:0]  r_result_src_w;
    logic [XLEN-1:0]   r_alu_result_w;
    logic [XLEN-1:0]   r_read_data_w;
    logic [XLEN-1:0]   r_pc_plus4_w;
    logic [XLEN-1:0]   w_result;

    // Word index; upper address bits are dropped so accesses wrap
    assign w_idx   = bus.ALUResultM[ADDR_W+1:2];

    // Unconditional combinational read -- kept free of any other logic
    assign w_rdata = r_mem[w_idx];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic              w_misalign;
    logic              r_misalign_w;
    logic [CNT_W-1:0]  r_misalign_cnt;

    // Access is a store or a load whose byte offset is nonzero
    assign w_misalign = (bus.MemWriteM || (bus.ResultSrcM == SRC_LOAD)) &&
                        (bus.ALUResultM[1:0] != 2'b00);

    // Misaligned stores never reach the array
    assign w_store_en = bus.MemWriteM && !w_misalign;

    // Sticky flag and saturating count of misaligned accesses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign_w   <= 1'b0;
            r_misalign_cnt <= '0;
        end else if (w_misalign) begin
            r_misalign_w <= 1'b1;
            if (r_misalign_cnt != {CNT_W{1'b1}}) begin
                r_misalign_cnt <= r_misalign_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.MisalignW   = r_misalign_w;
    assign bus.MisalignCnt = r_misalign_cnt;
`else
    // No alignment checking: byte offset ignored for every access
    assign w_store_en      = bus.MemWriteM;
    assign bus.MisalignW   = 1'b0;
    assign bus.MisalignCnt = '0;
`endif

    // Full-word store; suppressed while reset is held, including its first edge
    always_ff @(posedge clk or negedge rst) begin
        if (rst && w_store_en) begin
            r_mem[w_idx] <= bus.WriteDataM;
        end
    end

    // M/W pipeline register; advances every cycle, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write_w  <= 1'b0;
            r_rd_w         <= '0;
            r_result_src_w <= '0;
            r_alu_result_w <= '0;
            r_read_data_w  <= '0;
            r_pc_plus4_w   <= '0;
        end else begin
            r_reg_write_w  <= bus.RegWriteM;
            r_rd_w         <= bus.RdM;
            r_result_src_w <= bus.ResultSrcM;
            r_alu_result_w <= bus.ALUResultM;
            r_read_data_w  <= w_rdata;
            r_pc_plus4_w   <= bus.PCPlus4M;
        end
    end

    // Writeback result select; reserved encoding yields zero
    always_comb begin
        w_result = '0;
        case (r_result_src_w)
            SRC_ALU:  w_result = r_alu_result_w;
            SRC_LOAD: w_result = r_read_data_w;
            SRC_PC4:  w_result = r_pc_plus4_w;
            default:  w_result = '0;
        endcase
    end

    assign bus.RegWriteW  = r_reg_write_w;
    assign bus.RdW        = r_rd_w;
    assign bus.ResultSrcW = r_result_src_w;
    assign bus.ALUResultW = r_alu_result_w;
    assign bus.ReadDataW  = r_read_data_w;
    assign bus.PCPlus4W   = r_pc_plus4_w;
    assign bus.ResultW    = w_result;

endmodule

// File: tb/tb_memory_cycle.sv
// Testbench for memory_cycle: directed scenarios followed by random traffic,
// all compared against a behavioural word-array model of the memory stage.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_memory_cycle;

    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;

    memory_cycle_if bus ();

    memory_cycle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic        e_regw;
    logic [4:0]  e_rd;
    logic [1:0]  e_src;
    logic [31:0] e_alu;
    logic [31:0] e_rdata;
    logic [31:0] e_pc;
    logic        e_mis;
    int          e_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_result();
        case (e_src)
            2'd0:    return e_alu;
            2'd1:    return e_rdata;
            2'd2:    return e_pc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_all();
        check("RegWriteW",   32'(bus.RegWriteW),   32'(e_regw));
        check("RdW",         32'(bus.RdW),         32'(e_rd));
        check("ResultSrcW",  32'(bus.ResultSrcW),  32'(e_src));
        check("ALUResultW",  bus.ALUResultW,       e_alu);
        check("ReadDataW",   bus.ReadDataW,        e_rdata);
        check("PCPlus4W",    bus.PCPlus4W,         e_pc);
        check("ResultW",     bus.ResultW,          exp_result());
        check("MisalignW",   32'(bus.MisalignW),   32'(e_mis));
        check("MisalignCnt", 32'(bus.MisalignCnt), 32'(e_cnt));
    endtask

    task automatic model_reset();
        e_regw = 1'b0; e_rd = '0; e_src = '0; e_alu = '0;
        e_rdata = '0; e_pc = '0; e_mis = 1'b0; e_cnt = 0;
    endtask

    // One clock edge of the stage, described from the access rules
    task automatic model_capture(input logic regw, input logic we, input logic [1:0] src,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [4:0] rd, input logic [31:0] pc);
        int  idx;
        bit  mis;
        idx = int'((addr / 4) % DEPTH);
        mis = (we || src == 2'd1) && (addr % 4 != 0);
        e_rdata = m_mem[idx];
`ifdef DMEM_MISALIGN_TRAP_EN
        if (we && !mis) m_mem[idx] = wd;
        if (mis) begin
            e_mis = 1'b1;
            e_cnt = (e_cnt >= 255) ? 255 : e_cnt + 1;
        end
`else
        if (mis) begin end
        if (we) m_mem[idx] = wd;
`endif
        e_regw = regw; e_rd = rd; e_src = src; e_alu = addr; e_pc = pc;
    endtask

    // Drive one M-stage cycle at the falling edge, then check after the rising edge
    task automatic step(input logic r, input logic regw, input logic we, input logic [1:0] src,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] pc);
        @(negedge clk);
        rst            = r;
        bus.RegWriteM  = regw;
        bus.MemWriteM  = we;
        bus.ResultSrcM = src;
        bus.ALUResultM = addr;
        bus.WriteDataM = wd;
        bus.RdM        = rd;
        bus.PCPlus4M   = pc;
        #1;
        if (!r) begin
            model_reset();
            check_all();
        end
        @(posedge clk);
        if (r) model_capture(regw, we, src, addr, wd, rd, pc);
        #1;
        check_all();
    endtask

    task automatic step_rand_other(input logic r, input logic we, input logic [1:0] src,
                                   input logic [31:0] addr, input logic [31:0] wd);
        step(r, 1'($urandom), we, src, addr, wd, 5'($urandom), $urandom);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        model_reset();
        bus.RegWriteM = 1'b0; bus.MemWriteM = 1'b0; bus.ResultSrcM = '0;
        bus.ALUResultM = '0; bus.WriteDataM = '0; bus.RdM = '0; bus.PCPlus4M = '0;

        // Reset held with random M inputs (stores included) -> everything zero
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'($urandom), 1'b1, 2'($urandom), 32'h80 + 32'(i * 4),
                 $urandom, 5'($urandom), $urandom);
        check("reset_ResultW", bus.ResultW, 32'h0);

        // First edge after release captures the inputs
        step(1'b1, 1'b1, 1'b0, 2'd0, 32'h1234_5670, 32'h0, 5'd3, 32'h200);
        check("first_capture", bus.ResultW, 32'h1234_5670);

        // Store then load
        step_rand_other(1'b1, 1'b1, 2'd0, 32'h40, 32'hDEAD_BEEF);
        step(1'b1, 1'b1, 1'b0, 2'd1, 32'h40, 32'h0, 5'd9, 32'h0);
        check("load_data",   bus.ReadDataW, 32'hDEAD_BEEF);
        check("load_result", bus.ResultW,   32'hDEAD_BEEF);
        check("load_rd",     32'(bus.RdW),  32'd9);

        // Read-during-write returns old contents
        step_rand_other(1'b1, 1'b1, 2'd0, 32'h40, 32'h1111_1111);
        step_rand_other(1'b1, 1'b1, 2'd1, 32'h40, 32'h2222_2222);
        check("rdw_old", bus.ReadDataW, 32'h1111_1111);
        step_rand_other(1'b1, 1'b0, 2'd1, 32'h40, 32'h0);
        check("rdw_new", bus.ReadDataW, 32'h2222_2222);

        // Address wrap and result mux
        step_rand_other(1'b1, 1'b1, 2'd0, 32'h1000, 32'hA5A5_A5A5);
        step_rand_other(1'b1, 1'b0, 2'd1, 32'h0, 32'h0);
        check("wrap_load", bus.ResultW, 32'hA5A5_A5A5);
        step(1'b1, 1'b1, 1'b0, 2'd2, 32'h44, 32'h0, 5'd1, 32'h104);
        check("mux_pc4", bus.ResultW, 32'h104);
        step(1'b1, 1'b1, 1'b0, 2'd3, 32'h44, 32'h0, 5'd1, 32'h104);
        check("mux_rsvd", bus.ResultW, 32'h0);

        // Store in the reset-assertion cycle is dropped
        step_rand_other(1'b0, 1'b1, 2'd0, 32'h80, 32'h1234_5678);
        step_rand_other(1'b1, 1'b0, 2'd1, 32'h80, 32'h0);
        check("reset_store_dropped", bus.ReadDataW, 32'h0);

        // Misaligned store over a zero word
        step_rand_other(1'b1, 1'b1, 2'd0, 32'h40, 32'h0);
        step_rand_other(1'b1, 1'b1, 2'd0, 32'h42, 32'hFFFF_FFFF);
        step_rand_other(1'b1, 1'b0, 2'd1, 32'h40, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_word",  bus.ReadDataW,         32'h0);
        check("mis_flag",  32'(bus.MisalignW),    32'd1);
        check("mis_cnt",   32'(bus.MisalignCnt),  32'd1);
`else
        check("mis_word",  bus.ReadDataW,         32'hFFFF_FFFF);
        check("mis_flag",  32'(bus.MisalignW),    32'd0);
        check("mis_cnt",   32'(bus.MisalignCnt),  32'd0);
`endif
        for (int i = 0; i < 300; i++)
            step_rand_other(1'b1, 1'b0, 2'd1, 32'h101 + 32'(i * 4), 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_sat", 32'(bus.MisalignCnt), 32'hFF);
`else
        check("mis_sat", 32'(bus.MisalignCnt), 32'h0);
`endif

        // Random traffic over a small, aliased address window
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] addr;
            addr = 32'($urandom_range(0, 15) * 4) + 32'(DEPTH * 4 * $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(1, 3));
            step($urandom_range(0, 99) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
                 addr, $urandom, 5'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Pipeline memory stage (M) of the five-stage RV32 core. It sits directly downstream of the execute stage and consumes its M-stage outputs. It holds the word-addressed data memory, performs loads and stores, and registers the M/W pipeline boundary. It also drives the writeback result mux, whose output feeds back to the execute-stage forwarding muxes.

## Interface

Parameters:
- DEPTH, 1024: data memory size in 32-bit words; power of two.
- ADDR_W, log2(DEPTH) = 10: word-index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- RegWriteM  input  1  register-file write enable from E/M register.
- MemWriteM  input  1  store enable.
- ResultSrcM  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
- ALUResultM  input  32  byte address for load/store; ALU result otherwise.
- WriteDataM  input  32  store data (already forwarded).
- RdM  input  5  destination register.
- PCPlus4M  input  32  link value.
- RegWriteW  output  1  registered RegWriteM.
- RdW  output  5  registered RdM.
- ResultSrcW  output  2  registered ResultSrcM.
- ALUResultW  output  32  registered ALUResultM.
- ReadDataW  output  32  registered load data.
- PCPlus4W  output  32  registered PCPlus4M.
- ResultW  output  32  combinational writeback value.
- MisalignW  output  1  sticky misaligned-access flag.
- MisalignCnt  output  8  saturating misaligned-access count.

## Operation

- Word index = ALUResultM[ADDR_W+1:2]. Address bits above ADDR_W+1 are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Read: the memory array is read combinationally at the word index. The value is captured into ReadDataW at the clock edge. The read occurs every cycle regardless of ResultSrcM.
- Store: at the rising edge, if rst=1 and MemWriteM=1, the full 32-bit WriteDataM is written to the word index. There are no byte or halfword stores.
- Read-during-write to the same word in one cycle: ReadDataW receives the old contents (read-before-write).
- Memory contents are not affected by rst. They are zero-initialised at simulation start.
- M/W register: at each rising edge with rst=1, all *W registered outputs load their M counterparts. There is no stall or flush input; the stage advances every cycle.
- ResultW mux: 00 → ALUResultW; 01 → ReadDataW; 10 → PCPlus4W; 11 → 32'h0.
- Reset: while rst=0, all registered outputs are forced to zero asynchronously: RegWriteW, RdW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, MisalignW and MisalignCnt. ResultW is therefore 0.
- A reset asserted mid-operation discards the in-flight M/W contents. A store presented in the same cycle as reset assertion is not written.

## Timing

- Latency from M inputs to *W outputs is 1 cycle. ResultW is valid in the same cycle as the *W outputs.
- A store is visible to a load issued in the next cycle. Load data appears on ReadDataW 1 cycle after the load is in M.
- The memory read path is ALUResultM → array → ReadDataW D-input. This is the critical path and contains no other logic.
- Reset release is synchronous to clk. The first capture happens on the first rising edge with rst=1.

## Configuration

Macro: DMEM_MISALIGN_TRAP_EN.

- A misaligned access is defined as (MemWriteM=1 or ResultSrcM=01) with ALUResultM[1:0] ≠ 00.
- Defined:
  - A misaligned store is suppressed (the memory is not written).
  - MisalignW sets at the edge that captures the misaligned access and stays set until reset.
  - MisalignCnt increments by 1 per misaligned access and saturates at 8'hFF.
  - A misaligned load still returns the word at the truncated index.
- Not defined:
  - No alignment check; bits [1:0] are ignored for all accesses.
  - MisalignW and MisalignCnt are tied to 0.

## Test plan

- Reset: hold rst=0 with random M inputs → all *W outputs = 0, ResultW = 0. Release rst; the first edge captures the inputs.
- Store/load: store WriteDataM=32'hDEADBEEF at 0x40. Next cycle, load 0x40 with ResultSrcM=01 → one cycle later ReadDataW = ResultW = 32'hDEADBEEF, RdW matches.
- Read-during-write: word 0x40 holds 32'h11111111. Load and store 32'h22222222 to 0x40 in the same cycle → ReadDataW = 32'h11111111. The following load returns 32'h22222222.
- Wrap and mux: store 32'hA5A5A5A5 to address 0x1000 (DEPTH=1024) → a load of 0x0 returns 32'hA5A5A5A5. With ResultSrcM=10 and PCPlus4M=32'h104 → ResultW = 32'h104. With ResultSrcM=11 → ResultW = 0.
- Misalign with DMEM_MISALIGN_TRAP_EN defined: store 32'hFFFFFFFF to 0x42 over a word holding 0 → word unchanged, MisalignW=1, MisalignCnt=1. After 300 misaligned accesses, MisalignCnt = 8'hFF.
- Misalign without the macro: same store to 0x42 → word at 0x40 = 32'hFFFFFFFF, MisalignW=0, MisalignCnt=0.
